// File: rtl/lsu_mem_port.sv
// lsu_mem_port -- MEM-stage load/store unit, initiator side of the data-memory port.
//
// Accepts one load or store from the pipeline, checks alignment and funct3
// legality, issues a word-aligned request with byte enables over a
// req/gnt/rvalid handshake, and returns sign/zero-extended load data.
// The pipeline is stalled until the op completes, is rejected, or times out.
//
// Parameters:
//   TIMEOUT     max cycles spent in REQ+WAIT before the access is aborted (1..255)
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   ex_valid/ex_we      MEM stage holds an op / op is a store
//   ex_funct3           RV32I funct3 (LB/LH/LW/LBU/LHU, SB/SH/SW)
//   ex_addr/ex_wdata    byte address / store data (rs2)
//   stall               hold pipeline (combinational)
//   ld_valid/ld_data    one-cycle load-complete pulse / extended load result
//   err                 one-cycle pulse: misaligned, illegal funct3 or timeout
//   mem_req/mem_we/mem_be/mem_addr/mem_wdata   request to data memory
//   mem_gnt/mem_rvalid/mem_rdata               response from data memory
module lsu_mem_port #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ex_valid,
    input  logic        ex_we,
    input  logic [2:0]  ex_funct3,
    input  logic [31:0] ex_addr,
    input  logic [31:0] ex_wdata,
    output logic        stall,
    output logic        ld_valid,
    output logic [31:0] ld_data,
    output logic        err,
    output logic        mem_req,
    output logic        mem_we,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_gnt,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_REQ  = 3'd1,
        S_WAIT = 3'd2,
        S_DONE = 3'd3,
        S_ERR  = 3'd4
    } state_t;

    localparam logic [8:0] TIMEOUT_C = 9'(TIMEOUT);

    // Byte enables from access size (funct3[1:0]) and byte offset.
    function automatic logic [3:0] calc_be(input logic [1:0] size, input logic [1:0] off);
        logic [3:0] be;
        case (size)
            2'b00:   be = 4'b0001 << off;
            2'b01:   be = off[1] ? 4'b1100 : 4'b0011;
            2'b10:   be = 4'b1111;
            default: be = 4'b0000;
        endcase
        return be;
    endfunction

    // Store data replicated across lanes so any byte enable sees the right bytes.
    function automatic logic [31:0] calc_wdata(input logic [1:0] size, input logic [31:0] wdata);
        logic [31:0] wd;
        case (size)
            2'b00:   wd = {4{wdata[7:0]}};
            2'b01:   wd = {2{wdata[15:0]}};
            2'b10:   wd = wdata;
            default: wd = 32'd0;
        endcase
        return wd;
    endfunction

    // Shift the addressed lane down to bit 0, then sign- or zero-extend.
    function automatic logic [31:0] load_extract(input logic [2:0] f3, input logic [1:0] off,
                                                 input logic [31:0] rdata);
        logic [31:0] sh;
        logic [31:0] res;
        sh = rdata >> {off, 3'b000};
        case (f3)
            3'b000:  res = {{24{sh[7]}}, sh[7:0]};
            3'b001:  res = {{16{sh[15]}}, sh[15:0]};
            3'b010:  res = sh;
            3'b100:  res = {24'd0, sh[7:0]};
            3'b101:  res = {16'd0, sh[15:0]};
            default: res = 32'd0;
        endcase
        return res;
    endfunction

    // Legal funct3 for the direction and naturally aligned address.
    function automatic logic op_legal(input logic we, input logic [2:0] f3, input logic [1:0] off);
        logic ok;
        if (we) begin
            ok = (f3 < 3'd3);
        end else begin
            ok = (f3 != 3'd3) && (f3 != 3'd6) && (f3 != 3'd7);
        end
        case (f3[1:0])
            2'b01:   ok = ok && (off[0] == 1'b0);
            2'b10:   ok = ok && (off == 2'b00);
            default: ok = ok;
        endcase
        return ok;
    endfunction

    state_t      state_r;
    state_t      next_s;
    logic        op_we_r;
    logic [2:0]  op_funct3_r;
    logic [1:0]  op_off_r;
    logic [7:0]  cnt_r;
    logic        timeout_s;
    logic        accept_s;
    logic        legal_s;
    logic        req_we_s;

    logic        ld_valid_r;
    logic [31:0] ld_data_r;
    logic        err_r;
    logic        mem_req_r;
    logic        mem_we_r;
    logic [3:0]  mem_be_r;
    logic [31:0] mem_addr_r;
    logic [31:0] mem_wdata_r;

    // Stall is released only in the cycle the op retires (DONE) or is rejected (ERR).
    assign stall = ex_valid & (state_r != S_DONE) & (state_r != S_ERR);

    assign ld_valid  = ld_valid_r;
    assign ld_data   = ld_data_r;
    assign err       = err_r;
    assign mem_req   = mem_req_r;
    assign mem_we    = mem_we_r;
    assign mem_be    = mem_be_r;
    assign mem_addr  = mem_addr_r;
    assign mem_wdata = mem_wdata_r;

    // Next-state logic; timeout fires when this cycle would make the count reach TIMEOUT.
    always_comb begin
        next_s    = state_r;
        legal_s   = op_legal(ex_we, ex_funct3, ex_addr[1:0]);
        accept_s  = 1'b0;
        timeout_s = (({1'b0, cnt_r} + 9'd1) >= TIMEOUT_C);
        case (state_r)
            S_IDLE: begin
                if (ex_valid) begin
                    accept_s = legal_s;
                    next_s   = legal_s ? S_REQ : S_ERR;
                end else begin
                    next_s = S_IDLE;
                end
            end
            S_REQ: begin
                if (mem_gnt) begin
                    next_s = op_we_r ? S_DONE : S_WAIT;
                end else if (timeout_s) begin
                    next_s = S_ERR;
                end else begin
                    next_s = S_REQ;
                end
            end
            S_WAIT: begin
                if (mem_rvalid) begin
                    next_s = S_DONE;
                end else if (timeout_s) begin
                    next_s = S_ERR;
                end else begin
                    next_s = S_WAIT;
                end
            end
            S_DONE:  next_s = S_IDLE;
            S_ERR:   next_s = S_IDLE;
            default: next_s = S_IDLE;
        endcase
        // On entry to REQ the op registers are not loaded yet, so take we from ex_*.
        if (state_r == S_IDLE) begin
            req_we_s = ex_we;
        end else begin
            req_we_s = op_we_r;
        end
    end

    // State, latched op, timeout counter and all registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= S_IDLE;
            op_we_r     <= 1'b0;
            op_funct3_r <= 3'd0;
            op_off_r    <= 2'd0;
            cnt_r       <= 8'd0;
            ld_valid_r  <= 1'b0;
            ld_data_r   <= 32'd0;
            err_r       <= 1'b0;
            mem_req_r   <= 1'b0;
            mem_we_r    <= 1'b0;
            mem_be_r    <= 4'd0;
            mem_addr_r  <= 32'd0;
            mem_wdata_r <= 32'd0;
        end else begin
            state_r    <= next_s;
            mem_req_r  <= (next_s == S_REQ);
            mem_we_r   <= (next_s == S_REQ) & req_we_s;
            ld_valid_r <= (next_s == S_DONE) & ~op_we_r;
            err_r      <= (next_s == S_ERR);

            if (accept_s) begin
                op_we_r     <= ex_we;
                op_funct3_r <= ex_funct3;
                op_off_r    <= ex_addr[1:0];
                mem_addr_r  <= {ex_addr[31:2], 2'b00};
                mem_be_r    <= calc_be(ex_funct3[1:0], ex_addr[1:0]);
                mem_wdata_r <= ex_we ? calc_wdata(ex_funct3[1:0], ex_wdata) : 32'd0;
            end else begin
                op_we_r     <= op_we_r;
                op_funct3_r <= op_funct3_r;
                op_off_r    <= op_off_r;
                mem_addr_r  <= mem_addr_r;
                mem_be_r    <= mem_be_r;
                mem_wdata_r <= mem_wdata_r;
            end

            if (accept_s) begin
                cnt_r <= 8'd0;
            end else if ((state_r == S_REQ) || (state_r == S_WAIT)) begin
                cnt_r <= cnt_r + 8'd1;
            end else begin
                cnt_r <= cnt_r;
            end

            // rvalid is only meaningful while waiting for load data.
            if ((state_r == S_WAIT) && mem_rvalid) begin
                ld_data_r <= load_extract(op_funct3_r, op_off_r, mem_rdata);
            end else begin
                ld_data_r <= ld_data_r;
            end
        end
    end

endmodule

// File: tb/tb_lsu_mem_port.sv
module tb_lsu_mem_port;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ex_valid = 1'b0;
    logic        ex_we = 1'b0;
    logic [2:0]  ex_funct3 = 3'd0;
    logic [31:0] ex_addr = 32'd0;
    logic [31:0] ex_wdata = 32'd0;
    logic        stall, ld_valid, err, mem_req, mem_we;
    logic [31:0] ld_data, mem_addr, mem_wdata;
    logic [3:0]  mem_be;
    logic        mem_gnt = 1'b0;
    logic        mem_rvalid = 1'b0;
    logic [31:0] mem_rdata = 32'd0;

    // Second instance with a short timeout; its memory never answers.
    logic        to_ex_valid = 1'b0;
    logic        to_gnt = 1'b0;
    logic        to_rvalid = 1'b0;
    logic        to_stall, to_ld_valid, to_err, to_mem_req, to_mem_we;
    logic [31:0] to_ld_data, to_mem_addr, to_mem_wdata;
    logic [3:0]  to_mem_be;

    int vec_cnt = 0;
    int err_cnt = 0;

    always #5 clk = ~clk;

    lsu_mem_port dut (
        .clk(clk), .rst(rst), .ex_valid(ex_valid), .ex_we(ex_we), .ex_funct3(ex_funct3),
        .ex_addr(ex_addr), .ex_wdata(ex_wdata), .stall(stall), .ld_valid(ld_valid),
        .ld_data(ld_data), .err(err), .mem_req(mem_req), .mem_we(mem_we), .mem_be(mem_be),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_gnt(mem_gnt),
        .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
    );

    lsu_mem_port #(.TIMEOUT(4)) dut_to (
        .clk(clk), .rst(rst), .ex_valid(to_ex_valid), .ex_we(ex_we), .ex_funct3(ex_funct3),
        .ex_addr(ex_addr), .ex_wdata(ex_wdata), .stall(to_stall), .ld_valid(to_ld_valid),
        .ld_data(to_ld_data), .err(to_err), .mem_req(to_mem_req), .mem_we(to_mem_we),
        .mem_be(to_mem_be), .mem_addr(to_mem_addr), .mem_wdata(to_mem_wdata),
        .mem_gnt(to_gnt), .mem_rvalid(to_rvalid), .mem_rdata(mem_rdata)
    );

    // Advance one cycle and settle past the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        ex_valid = 1'b0;
        tick();
        tick();
        vec_cnt++;
        if ({ld_valid, err, mem_req, mem_we, stall} !== 5'b00000) begin
            err_cnt++;
            $display("FAIL reset_ctl: got %b want 00000", {ld_valid, err, mem_req, mem_we, stall});
        end
        vec_cnt++;
        if ({mem_be, mem_addr, mem_wdata, ld_data} !== 100'd0) begin
            err_cnt++;
            $display("FAIL reset_data: be %h addr %h wdata %h ld %h want all 0",
                     mem_be, mem_addr, mem_wdata, ld_data);
        end
        ex_valid = 1'b1;
        #1;
        vec_cnt++;
        if (stall !== 1'b1) begin
            err_cnt++;
            $display("FAIL reset_stall: got %b want 1", stall);
        end
        ex_valid = 1'b0;
        rst = 1'b0;
        tick();
    endtask

    task automatic test_lw();
        tick();                                   // C0
        ex_valid = 1'b1; ex_we = 1'b0; ex_funct3 = 3'd2; ex_addr = 32'h28;
        #1;
        vec_cnt++;
        if (stall !== 1'b1) begin err_cnt++; $display("FAIL lw_stall_c0: got %b want 1", stall); end
        tick();                                   // C1
        ex_addr = 32'h100; ex_funct3 = 3'd0;      // must not affect latched op
        vec_cnt++;
        if ({mem_req, mem_we, mem_be, mem_addr} !== {1'b1, 1'b0, 4'b1111, 32'h28}) begin
            err_cnt++;
            $display("FAIL lw_req: req %b we %b be %b addr %h want 1 0 1111 00000028",
                     mem_req, mem_we, mem_be, mem_addr);
        end
        vec_cnt++;
        if (stall !== 1'b1) begin err_cnt++; $display("FAIL lw_stall_c1: got %b want 1", stall); end
        mem_gnt = 1'b1;
        tick();                                   // C2
        mem_gnt = 1'b0;
        vec_cnt++;
        if ({mem_req, stall, ld_valid} !== 3'b010) begin
            err_cnt++;
            $display("FAIL lw_c2: req/stall/ldv %b want 010", {mem_req, stall, ld_valid});
        end
        mem_rvalid = 1'b1; mem_rdata = 32'h0000_0002;
        tick();                                   // C3
        mem_rvalid = 1'b0;
        vec_cnt++;
        if ({ld_valid, stall, ld_data} !== {1'b1, 1'b0, 32'h2}) begin
            err_cnt++;
            $display("FAIL lw_done: ldv %b stall %b data %h want 1 0 00000002", ld_valid, stall, ld_data);
        end
        ex_valid = 1'b0;
        tick();                                   // IDLE
        vec_cnt++;
        if (ld_valid !== 1'b0) begin err_cnt++; $display("FAIL lw_pulse: ld_valid %b want 0", ld_valid); end
    endtask

    task automatic test_load_extract();
        logic [2:0]  f3_t [5] = '{3'd0, 3'd4, 3'd5, 3'd1, 3'd0};
        logic [31:0] ad_t [5] = '{32'h0D, 32'h0D, 32'h0E, 32'h02, 32'h00};
        logic [31:0] rd_t [5] = '{32'h1234_80FF, 32'h1234_80FF, 32'h1234_80FF, 32'h8001_0000, 32'h0000_007F};
        logic [3:0]  be_t [5] = '{4'b0010, 4'b0010, 4'b1100, 4'b1100, 4'b0001};
        logic [31:0] ld_t [5] = '{32'hFFFF_FF80, 32'h0000_0080, 32'h0000_1234, 32'hFFFF_8001, 32'h0000_007F};
        for (int i = 0; i < 5; i++) begin
            tick();                               // C0
            ex_valid = 1'b1; ex_we = 1'b0; ex_funct3 = f3_t[i]; ex_addr = ad_t[i];
            tick();                               // C1
            vec_cnt++;
            if ({mem_req, mem_be, mem_addr} !== {1'b1, be_t[i], ad_t[i] & 32'hFFFF_FFFC}) begin
                err_cnt++;
                $display("FAIL ldx_req[%0d]: req %b be %b addr %h want 1 %b %h",
                         i, mem_req, mem_be, mem_addr, be_t[i], ad_t[i] & 32'hFFFF_FFFC);
            end
            mem_gnt = 1'b1;
            tick();                               // C2
            mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = rd_t[i];
            tick();                               // C3
            mem_rvalid = 1'b0;
            vec_cnt++;
            if ({ld_valid, ld_data} !== {1'b1, ld_t[i]}) begin
                err_cnt++;
                $display("FAIL ldx_data[%0d]: ldv %b data %h want 1 %h", i, ld_valid, ld_data, ld_t[i]);
            end
            ex_valid = 1'b0;
        end
        tick();
    endtask

    task automatic test_store();
        logic [2:0]  f3_t [2] = '{3'd0, 3'd1};
        logic [31:0] ad_t [2] = '{32'h13, 32'h12};
        logic [31:0] wd_t [2] = '{32'hAABB_CCDD, 32'h1122_3344};
        logic [3:0]  be_t [2] = '{4'b1000, 4'b1100};
        logic [31:0] mw_t [2] = '{32'hDDDD_DDDD, 32'h3344_3344};
        for (int i = 0; i < 2; i++) begin
            tick();                               // C0
            ex_valid = 1'b1; ex_we = 1'b1; ex_funct3 = f3_t[i]; ex_addr = ad_t[i]; ex_wdata = wd_t[i];
            tick();                               // C1
            vec_cnt++;
            if ({mem_req, mem_we, mem_be, mem_addr, mem_wdata} !==
                {1'b1, 1'b1, be_t[i], 32'h10, mw_t[i]}) begin
                err_cnt++;
                $display("FAIL st_req[%0d]: req %b we %b be %b addr %h wd %h want 1 1 %b 00000010 %h",
                         i, mem_req, mem_we, mem_be, mem_addr, mem_wdata, be_t[i], mw_t[i]);
            end
            vec_cnt++;
            if (stall !== 1'b1) begin err_cnt++; $display("FAIL st_stall_c1[%0d]: got %b want 1", i, stall); end
            mem_gnt = 1'b1;
            tick();                               // C2
            mem_gnt = 1'b0;
            vec_cnt++;
            if ({stall, ld_valid, mem_req, err} !== 4'b0000) begin
                err_cnt++;
                $display("FAIL st_done[%0d]: stall/ldv/req/err %b want 0000", i, {stall, ld_valid, mem_req, err});
            end
            ex_valid = 1'b0; ex_we = 1'b0;
        end
        tick();
    endtask

    task automatic test_misaligned();
        logic        we_t [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
        logic [2:0]  f3_t [4] = '{3'd2, 3'd1, 3'd3, 3'd2};
        logic [31:0] ad_t [4] = '{32'h06, 32'h05, 32'h00, 32'h01};
        int req_seen;
        for (int i = 0; i < 4; i++) begin
            req_seen = 0;
            tick();                               // C0
            ex_valid = 1'b1; ex_we = we_t[i]; ex_funct3 = f3_t[i]; ex_addr = ad_t[i];
            tick();                               // C1
            if (mem_req) req_seen++;
            vec_cnt++;
            if ({err, stall} !== 2'b10) begin
                err_cnt++;
                $display("FAIL mis_err[%0d]: err/stall %b want 10", i, {err, stall});
            end
            ex_valid = 1'b0;
            tick();                               // IDLE
            if (mem_req) req_seen++;
            vec_cnt++;
            if (err !== 1'b0 || req_seen != 0) begin
                err_cnt++;
                $display("FAIL mis_after[%0d]: err %b req_cycles %0d want 0 0", i, err, req_seen);
            end
        end
        ex_we = 1'b0;
    endtask

    task automatic test_delayed();
        int req_cyc = 0, lv_cnt = 0, lv_cyc = 0, stall_bad = 0, addr_bad = 0;
        logic [31:0] got_data = 32'd0;
        tick();                                   // C0
        ex_valid = 1'b1; ex_we = 1'b0; ex_funct3 = 3'd2; ex_addr = 32'h40;
        for (int cyc = 1; cyc <= 11; cyc++) begin
            tick();
            if (mem_req) begin
                req_cyc++;
                if (mem_addr !== 32'h40 || mem_be !== 4'b1111) addr_bad++;
            end
            if (ld_valid) begin lv_cnt++; lv_cyc = cyc; got_data = ld_data; end
            if (cyc < 8 && stall !== 1'b1) stall_bad++;
            mem_gnt = (cyc == 4);
            mem_rvalid = (cyc == 7);
            mem_rdata = (cyc == 7) ? 32'hCAFE_F00D : 32'h0;
            if (ld_valid) ex_valid = 1'b0;
        end
        mem_gnt = 1'b0; mem_rvalid = 1'b0; ex_valid = 1'b0;
        vec_cnt++;
        if (req_cyc != 4 || addr_bad != 0) begin
            err_cnt++;
            $display("FAIL dly_req: req_cycles %0d unstable %0d want 4 0", req_cyc, addr_bad);
        end
        vec_cnt++;
        if (lv_cnt != 1 || lv_cyc != 8 || got_data !== 32'hCAFE_F00D) begin
            err_cnt++;
            $display("FAIL dly_ld: pulses %0d at %0d data %h want 1 at 8 cafef00d", lv_cnt, lv_cyc, got_data);
        end
        vec_cnt++;
        if (stall_bad != 0) begin err_cnt++; $display("FAIL dly_stall: drops %0d want 0", stall_bad); end
    endtask

    task automatic test_timeout();
        int req_cyc = 0, err_n = 0, err_cyc = 0;
        tick();                                   // C0
        to_ex_valid = 1'b1; ex_we = 1'b0; ex_funct3 = 3'd2; ex_addr = 32'h80;
        for (int cyc = 1; cyc <= 8; cyc++) begin
            tick();
            if (to_mem_req) req_cyc++;
            if (to_err) begin err_n++; err_cyc = cyc; to_ex_valid = 1'b0; end
        end
        to_ex_valid = 1'b0;
        vec_cnt++;
        if (req_cyc != 4) begin err_cnt++; $display("FAIL to_req: req_cycles %0d want 4", req_cyc); end
        vec_cnt++;
        if (err_n != 1 || err_cyc != 5) begin
            err_cnt++;
            $display("FAIL to_err: pulses %0d at %0d want 1 at 5", err_n, err_cyc);
        end
    endtask

    task automatic test_reset_wait();
        int bad = 0;
        tick();                                   // C0
        ex_valid = 1'b1; ex_we = 1'b0; ex_funct3 = 3'd2; ex_addr = 32'h24;
        tick();                                   // C1
        mem_gnt = 1'b1;
        tick();                                   // C2: WAIT
        mem_gnt = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0; ex_valid = 1'b0;
        vec_cnt++;
        if ({mem_req, ld_valid, err} !== 3'b000) begin
            err_cnt++;
            $display("FAIL rstw_abort: req/ldv/err %b want 000", {mem_req, ld_valid, err});
        end
        mem_rvalid = 1'b1; mem_rdata = 32'h0000_DEAD;
        tick();
        mem_rvalid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            if (ld_valid || err || mem_req) bad++;
            tick();
        end
        vec_cnt++;
        if (bad != 0) begin err_cnt++; $display("FAIL rstw_late: spurious cycles %0d want 0", bad); end
        ex_valid = 1'b1; ex_addr = 32'h30;        // C0 of follow-up load
        tick();
        vec_cnt++;
        if ({mem_req, mem_addr} !== {1'b1, 32'h30}) begin
            err_cnt++;
            $display("FAIL rstw_req: req %b addr %h want 1 00000030", mem_req, mem_addr);
        end
        mem_gnt = 1'b1;
        tick();
        mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h5555_AAAA;
        tick();
        mem_rvalid = 1'b0;
        vec_cnt++;
        if ({ld_valid, ld_data} !== {1'b1, 32'h5555_AAAA}) begin
            err_cnt++;
            $display("FAIL rstw_next: ldv %b data %h want 1 5555aaaa", ld_valid, ld_data);
        end
        ex_valid = 1'b0;
        tick();
    endtask

    initial begin
        test_reset();
        test_lw();
        test_load_extract();
        test_store();
        test_misaligned();
        test_delayed();
        test_timeout();
        test_reset_wait();
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule

// File: doc/lsu_mem_port.md
# lsu_mem_port

Load/store unit for the MEM stage of the pipelined RISC-V core; it is the initiator side of the data-memory port. It accepts one load or store per instruction from the pipeline and issues a word-aligned request with byte enables over a req/gnt/rvalid handshake. For loads it extracts and sign- or zero-extends the addressed byte, halfword or word. It stalls the pipeline until the access completes, is rejected as misaligned or illegal, or times out.

## Interface
- TIMEOUT, 255: maximum cycles spent in REQ+WAIT before abort (1..255)
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- ex_valid  in  1  MEM stage holds a memory op
- ex_we  in  1  1 = store, 0 = load
- ex_funct3  in  3  RV32I funct3 (LB/LH/LW/LBU/LHU; SB/SH/SW)
- ex_addr  in  32  byte address
- ex_wdata  in  32  store data (rs2)
- stall  out  1  hold pipeline (combinational)
- ld_valid  out  1  one-cycle pulse, ld_data valid
- ld_data  out  32  extended load result
- err  out  1  one-cycle pulse: misaligned, illegal funct3 or timeout
- mem_req  out  1  request to data memory
- mem_we  out  1  request is a write
- mem_be  out  4  byte enables
- mem_addr  out  32  {addr[31:2],2'b00}
- mem_wdata  out  32  lane-replicated store data
- mem_gnt  in  1  memory accepted request
- mem_rvalid  in  1  read data valid
- mem_rdata  in  32  read word

## Operation
- FSM states: IDLE, REQ, WAIT, DONE, ERR.
- IDLE: when ex_valid=1, latch op and check legality.
  - Legal: go to REQ.
  - Misaligned (H with addr[0]=1; W with addr[1:0]≠0) or illegal funct3 (load 3/6/7, store ≥3): go to ERR; no memory request is issued.
- REQ: mem_req=1 with mem_* driven from the latched op.
  - On mem_gnt: store goes to DONE; load goes to WAIT.
  - mem_rvalid is ignored in REQ.
- WAIT: on mem_rvalid, capture the extracted load into ld_data and go to DONE.
- DONE: stall=0; ld_valid=1 for loads only. Next state IDLE.
- ERR: stall=0, err=1. Next state IDLE.
- stall = ex_valid & (state≠DONE) & (state≠ERR).
- Byte enables: B → 1<<addr[1:0]; H → addr[1] ? 4'b1100 : 4'b0011; W → 4'b1111. The same rule applies to loads.
- mem_wdata: SB → {4{wdata[7:0]}}; SH → {2{wdata[15:0]}}; SW → wdata. mem_wdata=0 for loads.
- Load extract: take rdata >> (8·addr[1:0]) and keep the low 8/16/32 bits. LB/LH sign-extend; LBU/LHU zero-extend.
- Timeout counter:
  - Cleared on entry to REQ; increments each cycle in REQ or WAIT.
  - When it reaches TIMEOUT: drop mem_req and go to ERR.
  - A late mem_rvalid arriving in IDLE/DONE/ERR is ignored.

## Timing
- Reset values: state IDLE; stall follows ex_valid; ld_valid, err, mem_req, mem_we = 0; mem_be, mem_addr, mem_wdata, ld_data = 0; counter 0.
- mem_*, ld_data, ld_valid and err are registered; only stall is combinational.
- Minimum latency, counted from the first ex_valid cycle (C0): store with gnt in C1 completes in C2. Load with gnt in C1 and rvalid in C2 completes in C3.
- Stall is released in the DONE/ERR cycle; the pipeline advances at the end of that cycle. One IDLE cycle always precedes the next op.
- The latched op is immune to ex_* changes after C0.
- rst asserted in any state: at the next edge go to IDLE and drop mem_req. No ld_valid or err is emitted for the aborted op.

## Test plan
- LW addr 0x28, memory returns 0x00000002 one cycle after gnt → mem_addr 0x28, mem_be 1111, ld_valid in C3, ld_data 0x00000002, stall high C0–C2.
- LB addr 0x0D, rdata 0x1234_80FF → mem_be 0010, ld_data 0xFFFFFF80. LBU same → 0x00000080. LHU addr 0x0E → 0x00001234.
- SB addr 0x13, wdata 0xAABBCCDD → mem_we 1, mem_be 1000, mem_wdata 0xDDDDDDDD, mem_addr 0x10, stall released C2, no ld_valid.
- LW addr 0x06 and LH addr 0x05 → err pulse in C1, mem_req never asserted. Load funct3=3 → err.
- gnt delayed 3 cycles, then rvalid delayed 2 → mem_req held stable 4 cycles, stall held throughout, ld_valid exactly once. With TIMEOUT=4 and no gnt → err after 4 REQ cycles, mem_req drops.
- rst asserted in WAIT → IDLE next cycle, mem_req 0, subsequent rvalid ignored, next LW completes normally.
